// File: rtl/mt_ifetch_queue_pkg.sv
// Shared types and defaults for the multi-thread instruction-fetch front end.
package mt_ifetch_queue_pkg;

    localparam int unsigned DEF_NUM_THREADS = 4;
    localparam int unsigned DEF_FQ_DEPTH    = 4;
    localparam int unsigned DEF_ROM_LAT     = 1;
    localparam logic [31:0] PC_STEP         = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Single-thread instruction queue: push, pop, flush, registered head and occupancy count.
module ifq_fifo
    import mt_ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fq_entry_t                push_data,
    input  logic                     pop,
    output logic                     head_vld,
    output fq_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fq_entry_t          mem_q [DEPTH];
    fq_entry_t          mem_d [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               head_vld_q, head_vld_d;
    fq_entry_t          head_q, head_d;
    logic               pop_eff;

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        head_vld_d = head_vld_q;
        head_d     = head_q;
        pop_eff    = pop & head_vld_q;

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            head_vld_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d    = count_q + CW'(push) - CW'(pop_eff);
            head_vld_d = (count_d != '0);
            // When the queue drains to nothing before this push, the new head is the pushed entry itself.
            if (count_d != '0) begin
                head_d = (count_q == CW'(pop_eff)) ? push_data : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    assign head_vld = head_vld_q;
    assign head     = head_q;
    assign count    = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !flush) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/mt_ifetch_queue.sv
// Multi-thread fetch front end: per-thread PC, credit-limited fixed-latency ROM pipe and instruction queue.
module mt_ifetch_queue
    import mt_ifetch_queue_pkg::*;
#(
    parameter int unsigned NUM_THREADS     = DEF_NUM_THREADS,
    parameter int unsigned FQ_DEPTH        = DEF_FQ_DEPTH,
    parameter int unsigned ROM_LAT         = DEF_ROM_LAT,
    parameter logic [31:0] RESET_PC_STRIDE = 32'h0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_THREADS-1:0]        thread_en,
    input  logic [NUM_THREADS-1:0]        hold,
    input  logic [NUM_THREADS-1:0]        jump_en,
    input  logic [31:0]                   jump_addr [NUM_THREADS],
    output logic [NUM_THREADS-1:0]        rom_req,
    output logic [31:0]                   rom_addr  [NUM_THREADS],
    input  logic [31:0]                   rom_ins   [NUM_THREADS],
    output logic [NUM_THREADS-1:0]        ins_vld,
    output logic [31:0]                   ins       [NUM_THREADS],
    output logic [31:0]                   pc2id_ex  [NUM_THREADS],
    input  logic [NUM_THREADS-1:0]        pop,
    output logic [$clog2(FQ_DEPTH):0]     q_count   [NUM_THREADS]
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]          pc_q   [NUM_THREADS];
    logic [31:0]          pc_d   [NUM_THREADS];
    logic [ROM_LAT-1:0]   pv_q   [NUM_THREADS];
    logic [ROM_LAT-1:0]   pv_d   [NUM_THREADS];
    logic [31:0]          ptag_q [NUM_THREADS][ROM_LAT];
    logic [31:0]          ptag_d [NUM_THREADS][ROM_LAT];

    logic [NUM_THREADS-1:0] issue;
    logic [NUM_THREADS-1:0] land;
    logic [NUM_THREADS-1:0] head_vld;
    fq_entry_t              push_data [NUM_THREADS];
    fq_entry_t              head      [NUM_THREADS];
    logic [CW-1:0]          cnt       [NUM_THREADS];

    always_comb begin
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            // Queued plus in-flight never exceeds FQ_DEPTH, so every response has a free slot.
            issue[t] = ~rst & thread_en[t] & ~hold[t] & ~jump_en[t]
                     & ((int'(cnt[t]) + $countones(pv_q[t])) < int'(FQ_DEPTH));
            land[t]  = pv_q[t][ROM_LAT-1] & ~jump_en[t];
            push_data[t] = '{pc: ptag_q[t][ROM_LAT-1], ins: rom_ins[t]};

            pc_d[t]      = pc_q[t];
            pv_d[t][0]   = issue[t];
            ptag_d[t][0] = pc_q[t];
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                pv_d[t][k]   = pv_q[t][k-1];
                ptag_d[t][k] = ptag_q[t][k-1];
            end

            if (jump_en[t]) begin
                pc_d[t] = {jump_addr[t][31:2], 2'b00};
                pv_d[t] = '0;
            end else if (issue[t]) begin
                pc_d[t] = pc_q[t] + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= 32'(t) * RESET_PC_STRIDE;
                pv_q[t] <= '0;
                for (int unsigned k = 0; k < ROM_LAT; k++) begin
                    ptag_q[t][k] <= '0;
                end
            end
        end else begin
            pc_q   <= pc_d;
            pv_q   <= pv_d;
            ptag_q <= ptag_d;
        end
    end

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_thr
        ifq_fifo #(
            .DEPTH (FQ_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (jump_en[g]),
            .push      (land[g]),
            .push_data (push_data[g]),
            .pop       (pop[g]),
            .head_vld  (head_vld[g]),
            .head      (head[g]),
            .count     (cnt[g])
        );

        assign rom_addr[g] = pc_q[g];
        assign ins[g]      = head[g].ins;
        assign pc2id_ex[g] = head[g].pc;
        assign q_count[g]  = cnt[g];
    end

    assign rom_req = issue;
    assign ins_vld = head_vld;

endmodule

// File: tb/tb_mt_ifetch_queue.sv
// Bench for mt_ifetch_queue: directed vector table, hand sequences and a queue-based reference model under random traffic.
module tb_mt_ifetch_queue;

    localparam int unsigned NT     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LAT    = 1;
    localparam logic [31:0] STRIDE = 32'h40;
    localparam int unsigned QW     = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NT-1:0]   thread_en = '0;
    logic [NT-1:0]   hold = '0;
    logic [NT-1:0]   jump_en = '0;
    logic [NT-1:0]   pop = '0;
    logic [31:0]     jump_addr [NT];
    logic [NT-1:0]   rom_req;
    logic [31:0]     rom_addr  [NT];
    logic [31:0]     rom_ins   [NT];
    logic [NT-1:0]   ins_vld;
    logic [31:0]     ins       [NT];
    logic [31:0]     pc2id_ex  [NT];
    logic [QW-1:0]   q_count   [NT];

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    mt_ifetch_queue #(
        .NUM_THREADS     (NT),
        .FQ_DEPTH        (DEPTH),
        .ROM_LAT         (LAT),
        .RESET_PC_STRIDE (STRIDE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .thread_en (thread_en),
        .hold      (hold),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ins   (rom_ins),
        .ins_vld   (ins_vld),
        .ins       (ins),
        .pc2id_ex  (pc2id_ex),
        .pop       (pop),
        .q_count   (q_count)
    );

    function automatic logic [31:0] romf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s thr%0d @%0t: got %h expected %h", name, t, $time, act, exp);
        end
    endtask

    // ROM: returns romf(addr) exactly LAT cycles after the address was presented
    logic [31:0] rom_pipe [NT][LAT];
    always @(posedge clk) begin
        for (int t = 0; t < NT; t++) begin
            rom_pipe[t][0] <= rom_addr[t];
            for (int k = 1; k < LAT; k++) rom_pipe[t][k] <= rom_pipe[t][k-1];
        end
    end
    always_comb begin
        for (int t = 0; t < NT; t++) rom_ins[t] = romf(rom_pipe[t][LAT-1]);
    end

    // Reference model: queue of head PCs, list of outstanding fetches with landing edge
    typedef struct {
        logic [31:0] pc;
        int unsigned land;
    } infl_t;

    logic [31:0] mq [NT][$];
    infl_t       mf [NT][$];
    logic [31:0] mpc [NT];
    int unsigned edge_n = 0;

    function automatic logic exp_req(input int t);
        return !rst && thread_en[t] && !hold[t] && !jump_en[t]
               && ((mq[t].size() + mf[t].size()) < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NT; t++) begin
                mq[t].delete();
                mf[t].delete();
                mpc[t] = 32'(t) * STRIDE;
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                logic req;
                req = exp_req(t);
                if (jump_en[t]) begin
                    mq[t].delete();
                    mf[t].delete();
                    mpc[t] = jump_addr[t] & 32'hFFFF_FFFC;
                end else begin
                    if (pop[t] && mq[t].size() > 0) void'(mq[t].pop_front());
                    if (mf[t].size() > 0 && mf[t][0].land == edge_n) begin
                        mq[t].push_back(mf[t][0].pc);
                        void'(mf[t].pop_front());
                    end
                    if (req) begin
                        mf[t].push_back('{pc: mpc[t], land: edge_n + LAT});
                        mpc[t] = mpc[t] + 32'd4;
                    end
                end
            end
            edge_n++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int t = 0; t < NT; t++) begin
                check("m_rom_req", t, 32'(rom_req[t]), 32'(exp_req(t)));
                check("m_rom_addr", t, rom_addr[t], mpc[t]);
                check("m_q_count", t, 32'(q_count[t]), mq[t].size());
                check("m_ins_vld", t, 32'(ins_vld[t]), 32'(mq[t].size() > 0));
                if (mq[t].size() > 0) begin
                    check("m_pc2id_ex", t, pc2id_ex[t], mq[t][0]);
                    check("m_ins", t, ins[t], romf(mq[t][0]));
                end
            end
        end
    end

    typedef struct {
        logic        en, hld, jmp;
        logic [31:0] ja;
        logic        pp;
        logic        req;
        logic [31:0] addr;
        int          cnt;
        logic        vld;
        logic [31:0] hpc;
    } vec_t;

    vec_t tbl [19];

    initial begin
        for (int t = 0; t < NT; t++) jump_addr[t] = '0;

        // thread 0 only; en, hold, jmp, ja, pop | rom_req, rom_addr, q_count, ins_vld, head pc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h008, 1, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 2, 1'b1, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 3, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h010, 4, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 4, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 3, 1'b1, 32'h4};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h014, 2, 1'b1, 32'h8};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 0, 1'b0, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h208, 1, 1'b1, 32'h200};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 2, 1'b1, 32'h200};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 1, 1'b1, 32'h204};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h208, 0, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20C, 0, 1'b0, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h210, 1, 1'b1, 32'h208};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h214, 1, 1'b1, 32'h20C};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h218, 1, 1'b1, 32'h210};

        // Reset with threads enabled: no requests, empty heads, staggered reset PCs
        thread_en = '1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        for (int t = 0; t < NT; t++) begin
            check("rst_rom_req", t, 32'(rom_req[t]), 32'h0);
            check("rst_rom_addr", t, rom_addr[t], 32'(t) * STRIDE);
            check("rst_ins_vld", t, 32'(ins_vld[t]), 32'h0);
            check("rst_q_count", t, 32'(q_count[t]), 32'h0);
            check("rst_ins", t, ins[t], 32'h0);
            check("rst_pc2id_ex", t, pc2id_ex[t], 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        thread_en = '0;

        for (int k = 0; k < 19; k++) begin
            thread_en[0]  = tbl[k].en;
            hold[0]       = tbl[k].hld;
            jump_en[0]    = tbl[k].jmp;
            jump_addr[0]  = tbl[k].ja;
            pop[0]        = tbl[k].pp;
            @(negedge clk);
            check("v_rom_req", k, 32'(rom_req[0]), 32'(tbl[k].req));
            check("v_rom_addr", k, rom_addr[0], tbl[k].addr);
            check("v_q_count", k, 32'(q_count[0]), tbl[k].cnt);
            check("v_ins_vld", k, 32'(ins_vld[0]), 32'(tbl[k].vld));
            if (tbl[k].vld) begin
                check("v_pc2id_ex", k, pc2id_ex[0], tbl[k].hpc);
                check("v_ins", k, ins[0], romf(tbl[k].hpc));
            end
            @(posedge clk);
            #1;
        end
        thread_en = '0;
        hold = '0;
        jump_en = '0;
        pop = '0;

        // PC wrap: misaligned jump near the top of the address space on thread 1
        thread_en[1] = 1'b1;
        jump_en[1]   = 1'b1;
        jump_addr[1] = 32'hFFFF_FFFE;
        @(negedge clk);
        check("wrap_no_req_on_jump", 1, 32'(rom_req[1]), 32'h0);
        @(posedge clk);
        #1;
        jump_en[1] = 1'b0;
        @(negedge clk);
        check("wrap_req", 1, 32'(rom_req[1]), 32'h1);
        check("wrap_addr_top", 1, rom_addr[1], 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wrap_addr_zero", 1, rom_addr[1], 32'h0000_0000);
        @(posedge clk);
        #1;

        // Random traffic with an asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b1;
                @(negedge clk);
                for (int t = 0; t < NT; t++) begin
                    check("mid_rst_q_count", t, 32'(q_count[t]), 32'h0);
                    check("mid_rst_ins_vld", t, 32'(ins_vld[t]), 32'h0);
                    check("mid_rst_rom_req", t, 32'(rom_req[t]), 32'h0);
                    check("mid_rst_rom_addr", t, rom_addr[t], 32'(t) * STRIDE);
                end
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            for (int t = 0; t < NT; t++) begin
                thread_en[t] = ($urandom_range(9) != 0);
                hold[t]      = ($urandom_range(4) == 0);
                jump_en[t]   = ($urandom_range(19) == 0);
                pop[t]       = ($urandom_range(9) < 6);
                jump_addr[t] = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                        : 32'($urandom);
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
